// File: rtl/seq_ripple_addsub.sv
// seq_ripple_addsub
//   Multi-cycle ripple-carry adder/subtractor. The WIDTH-bit carry chain is cut
//   into NSLICE = WIDTH/CHUNK slices; one slice is evaluated per clock and the
//   carry is held in c_r between slices. Subtraction is A + ~B + 1.
//
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous, active-high reset
//   start : request, sampled only in IDLE
//   sub   : 0 = a+b+cin, 1 = a-b (cin ignored)
//   a, b  : WIDTH-bit operands, captured on the accepting edge only
//   cin   : carry-in, add mode only
//   busy  : high for the NSLICE cycles the chain is being evaluated
//   done  : one-cycle pulse, sum/cout/ovf valid
//   sum   : registered result, updated only on completion
//   cout  : carry out of the MSB (sub mode: 1 = no borrow)
//   ovf   : signed overflow
module seq_ripple_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("seq_ripple_addsub: illegal WIDTH/CHUNK combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r, res_r;
  logic             c_r;
  logic [KW-1:0]    k;

  // Current slice of the chain
  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             c_nxt, c_msb;
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    a_sl = a_r[int'(k)*CHUNK +: CHUNK];
    b_sl = b_r[int'(k)*CHUNK +: CHUNK];
    {c_nxt, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, c_r};
    // Carry into the top bit of the slice, recovered from the sum bit. Only
    // meaningful on the last slice, where it is the carry into bit WIDTH-1.
    c_msb = s_sl[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
    res_nxt = res_r;
    res_nxt[int'(k)*CHUNK +: CHUNK] = s_sl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      c_r   <= 1'b0;
      k     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            c_r   <= sub ? 1'b1 : cin;
            k     <= '0;
            busy  <= 1'b1;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          res_r <= res_nxt;
          c_r   <= c_nxt;
          if (k == K_LAST) begin
            sum   <= res_nxt;
            cout  <= c_nxt;
            ovf   <= c_msb ^ c_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ripple_addsub.sv
// Bench for seq_ripple_addsub: three builds (CHUNK = 4, 16, 1) share one
// stimulus stream. Each build has its own cycle model and expected-result
// queue; results are pushed on acceptance and popped on completion.
module tb_seq_ripple_addsub;

  localparam int W  = 16;
  localparam int ND = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic [ND-1:0] busy_w, done_w, cout_w, ovf_w;
  logic [W-1:0]  sum_w [ND];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic int chunk_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 16 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum}
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                                          input logic osub, input logic ocin);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         v;
    bb   = osub ? ~ob : ob;
    full = {1'b0, oa} + {1'b0, bb} + {{W{1'b0}}, (osub ? 1'b1 : ocin)};
    v    = (oa[W-1] == bb[W-1]) && (full[W-1] != oa[W-1]);
    return {v, full};
  endfunction

  generate
    for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int CH = (g == 0) ? 4 : (g == 1) ? 16 : 1;
      localparam int NS = W / CH;

      seq_ripple_addsub #(.WIDTH(W), .CHUNK(CH)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy_w[g]),
        .done  (done_w[g]),
        .sum   (sum_w[g]),
        .cout  (cout_w[g]),
        .ovf   (ovf_w[g])
      );

      logic [W+1:0] sb_q[$];
      logic [W+1:0] held = '0;
      int           ph = 0;   // 0 idle, 1 busy, 2 done
      int           bc = 0;

      always begin
        @(posedge clk);
        if (rst) begin
          ph = 0; bc = 0; held = '0;
          sb_q.delete();
        end else begin
          case (ph)
            0: if (start) begin
                 sb_q.push_back(ref_op(a, b, sub, cin));
                 ph = 1;
                 bc = NS;
               end
            1: begin
                 bc--;
                 if (bc == 0) begin
                   if (sb_q.size() == 0) chk($sformatf("sb_underflow[%0d]", g), 0, 1);
                   else held = sb_q.pop_front();
                   ph = 2;
                 end
               end
            default: ph = 0;
          endcase
        end
        #1;
        chk($sformatf("busy[%0d]", g), 32'(busy_w[g]), 32'(ph == 1));
        chk($sformatf("done[%0d]", g), 32'(done_w[g]), 32'(ph == 2));
        chk($sformatf("sum[%0d]",  g), 32'(sum_w[g]),  32'(held[W-1:0]));
        chk($sformatf("cout[%0d]", g), 32'(cout_w[g]), 32'(held[W]));
        chk($sformatf("ovf[%0d]",  g), 32'(ovf_w[g]),  32'(held[W+1]));
      end
    end
  endgenerate

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("%s_busy[%0d]", tag, i), 32'(busy_w[i]), 0);
      chk($sformatf("%s_done[%0d]", tag, i), 32'(done_w[i]), 0);
      chk($sformatf("%s_sum[%0d]",  tag, i), 32'(sum_w[i]),  0);
      chk($sformatf("%s_cout[%0d]", tag, i), 32'(cout_w[i]), 0);
      chk($sformatf("%s_ovf[%0d]",  tag, i), 32'(ovf_w[i]),  0);
    end
  endtask

  // One start pulse, then scramble the operand inputs while all builds run.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic osub, input logic ocin, input bit ck,
                       input logic [W-1:0] es, input logic ec, input logic eo,
                       input string tag);
    int            bcnt [ND];
    logic [ND-1:0] seen;
    seen = '0;
    for (int i = 0; i < ND; i++) bcnt[i] = 0;
    @(negedge clk);
    a = oa; b = ob; sub = osub; cin = ocin; start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        sub = 1'($urandom); cin = 1'($urandom);
      end
      for (int i = 0; i < ND; i++) if (busy_w[i]) bcnt[i]++;
      seen |= done_w;
      if (seen == '1) break;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'({ND{1'b1}}));
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("%s_busy_len[%0d]", tag, i), 32'(bcnt[i]), 32'(W / chunk_of(i)));
      if (ck) begin
        chk($sformatf("%s_sum[%0d]",  tag, i), 32'(sum_w[i]),  32'(es));
        chk($sformatf("%s_cout[%0d]", tag, i), 32'(cout_w[i]), 32'(ec));
        chk($sformatf("%s_ovf[%0d]",  tag, i), 32'(ovf_w[i]),  32'(eo));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [ND-1:0] seen;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_init");
    @(negedge clk) rst = 1'b0;

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, "add_basic");
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "add_wrap");
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, "add_ovf");
    do_op(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, "add_cin");
    do_op(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_cin_ign");
    do_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b1, 16'hBCDE, 1'b0, 1'b0, "add_abcd");

    // Reset during the second busy cycle: no done pulse follows
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_mid");
    @(negedge clk) rst = 1'b0;
    seen = '0;
    repeat (20) begin
      @(negedge clk);
      seen |= done_w;
    end
    chk("rst_mid_no_done", 32'(seen), 0);
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, "after_rst");

    // start held high with operands changing every cycle
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
    repeat (60) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom);
      sub = 1'($urandom); cin = 1'($urandom);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    // Random ops, with corner operands mixed in
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      logic [W+1:0] r;
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 16'hFFFF;
        1: rb = 16'h8000;
        2: ra = 16'h7FFF;
        3: rb = 16'h0000;
        default: ;
      endcase
      r = ref_op(ra, rb, 1'($urandom), 1'b0);
      do_op(ra, rb, 1'(n % 2), 1'($urandom), 1'b0, r[W-1:0], r[W], r[W+1], "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
